sram_ctrl: RTL and testbench
============================

# sram_ctrl

Multi-cycle controller that sequences the MEM stage's data-memory accesses onto an external 16-bit asynchronous SRAM. Each 32-bit load or store becomes two halfword beats with programmable wait states. While an access is in flight, `ready` is held low so the hazard/freeze logic stalls every pipeline stage. The block sits between the MEM stage's `MEM_R_EN`/`MEM_W_EN`/ALU-address/store-value signals and the SRAM pins.

## Interface
- `BASE_ADDR`, default 1024: byte address mapped to SRAM halfword 0.
- `WAIT_STATES`, default 1: write-strobe cycles per beat. Legal range 1..15.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: store request from the MEM stage.
- `rd_en` in 1: load request from the MEM stage.
- `address` in 32: byte address (ALU result). Word-aligned.
- `wr_data` in 32: store value.
- `rd_data` out 32: load result, registered.
- `ready` out 1: 1 = no stall; 0 = freeze pipeline.
- `sram_addr` out 18: halfword address.
- `sram_dq_out` out 16: write data to pad.
- `sram_dq_oe` out 1: 1 = drive `sram_dq_out` onto the bus.
- `sram_dq_in` in 16: read data from pad.
- `sram_we_n` out 1: active-low write strobe.
- `sram_oe_n` out 1: active-low output enable.

## Operation
- The FSM has four states: IDLE, LO, HI, DONE. It uses a beat counter `cnt` (4 bits) that counts 0..WAIT_STATES. A beat is therefore WAIT_STATES+1 cycles long.
- **IDLE**
  - `ready` = !(rd_en | wr_en).
  - If a request is present, latch op, address and wr_data, clear `cnt`, and go to LO.
  - If `wr_en` and `rd_en` are both 1, this is illegal; the write wins.
- **Address mapping:** idx = (address − BASE_ADDR) >> 2, truncated to 17 bits.
  - LO uses `sram_addr` = {idx, 0} and data bits [15:0].
  - HI uses `sram_addr` = {idx, 1} and data bits [31:16].
- **Each beat**
  - `sram_addr` is stable for the whole beat.
  - Write: `sram_dq_oe`=1. `sram_we_n`=0 while `cnt` < WAIT_STATES, and 1 in the final cycle.
  - Read: `sram_oe_n`=0 for the whole beat. `sram_dq_in` is captured into the matching half of `rd_data` in the final cycle (`cnt`==WAIT_STATES).
  - When `cnt`==WAIT_STATES: LO goes to HI, HI goes to DONE, and `cnt` clears.
- **DONE**
  - `ready`=1 for exactly one cycle; the pipeline advances on this edge.
  - Next state is unconditionally IDLE.
- `rd_data` holds its value until the next read overwrites it. Writes never modify it.
- Outside the LO and HI states, the SRAM outputs are idle: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `rd_data` 0, `sram_we_n` 1, `sram_oe_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `sram_dq_out` 0. `ready` then follows the IDLE rule.
- **Stall length:** `ready` is low for 2·(WAIT_STATES+1)+1 consecutive cycles (IDLE + LO + HI), then high for one cycle (DONE).
  - With WAIT_STATES=1: 5 cycles low, then 1 cycle high.
- **Request-to-data latency:** `rd_data` is valid in the DONE cycle.
- **Back-to-back requests:** after DONE the FSM returns to IDLE. A request present there starts a new access with no extra bubble.
- **Request outside IDLE:** request inputs are ignored in LO, HI and DONE; the latched copies are used.
- **Reset mid-access:** an `rst` high on any edge forces IDLE and the reset values listed above. No further write strobe is emitted, and the partially written word is left as-is.
- **Pin registration:** all SRAM outputs are registered. `ready` is combinational from state and the request inputs.

## Structure
- **Package `sram_ctrl_pkg`:**
  - state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3);
  - the defaults for `BASE_ADDR` and `WAIT_STATES`;
  - the SRAM address width (18) and data width (16).
- **Sub-module `sram_beat_timer`:** the beat counter.
  - Inputs: `clk`, `rst`, `start`, `wait_states`.
  - Outputs: `cnt` and `last` (asserted when `cnt`==WAIT_STATES).
- The FSM and datapath live in `sram_ctrl`.
- The bidirectional pad is instantiated outside this block, at top level.

## Test plan
- **Store then load:** store 0xDEADBEEF to address 1024 (WAIT_STATES=1).
  - Required: halfword 0 receives 0xBEEF and halfword 1 receives 0xDEAD; `sram_we_n` is low exactly 1 cycle per beat; `ready` is low for 5 cycles.
  - Then load 1024. Required: `rd_data`=0xDEADBEEF in the DONE cycle.
- **Address mapping:** load from address 1032.
  - Required: `sram_addr` is 4 in LO and 5 in HI.
  - With SRAM model contents {0x5678, 0x1234}, `rd_data`=0x12345678.
- **Back-to-back:** store immediately followed by a load with no idle gap.
  - Required: exactly one DONE cycle between the two accesses, and the second access's IDLE cycle occurs right after DONE.
- **Reset mid-access:** `rst` asserted during HI of a store.
  - Required: next cycle `sram_we_n`=1, `sram_dq_oe`=0, `rd_data`=0, and `ready`=1 when no request is present.
- **Conflict and hold:** `rd_en`=`wr_en`=1.
  - Required: a write is performed and `rd_data` is unchanged.
  - With WAIT_STATES=3, `ready` is low for 9 cycles.
- **Idle:** no requests for 20 cycles.
  - Required: `ready`=1 throughout, `sram_oe_n`=`sram_we_n`=1, and `rd_data` stable.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_WAIT_STATES = 1;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response signals and external SRAM pins.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        wr_data;
  logic [31:0]        rd_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_out;
  logic               sram_dq_oe;
  logic [SRAM_DW-1:0] sram_dq_in;
  logic               sram_we_n;
  logic               sram_oe_n;

  // Controller side.
  modport slave (
    input  wr_en, rd_en, address, wr_data, sram_dq_in,
    output rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  // Pipeline / board side.
  modport master (
    output wr_en, rd_en, address, wr_data, sram_dq_in,
    input  rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/sram_beat_timer.sv
// Beat counter: runs 0..wait_states, wrapping to 0 after the final cycle.
module sram_beat_timer
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] wait_states,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == wait_states);

  // Clear on start or at the end of a beat, otherwise advance one cycle.
  always_ff @(posedge clk) begin
    if (rst || start || last) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Sequences a 32-bit MEM-stage load/store as two halfword beats on a
// 16-bit asynchronous SRAM, stalling the pipeline until the access is done.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_t             state, state_nxt;
  logic               req;
  logic               wr_q;
  logic [31:0]        addr_q, data_q;
  logic               op_wr;
  logic [31:0]        addr_src, data_src;
  logic [16:0]        idx;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last, start;
  logic               in_beat, hi_nxt;

  assign req = bus.rd_en | bus.wr_en;

  // The counter is held clear outside the LO/HI beats.
  assign start   = (state == IDLE) || (state == DONE);
  assign cnt_nxt = (start || last) ? '0 : cnt + 1'b1;

  sram_beat_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .wait_states (WS),
    .cnt         (cnt),
    .last        (last)
  );

  // In IDLE the pins for the first beat come straight from the request inputs,
  // because the latched copies only become valid on the same edge.
  assign op_wr    = (state == IDLE) ? bus.wr_en   : wr_q;
  assign addr_src = (state == IDLE) ? bus.address : addr_q;
  assign data_src = (state == IDLE) ? bus.wr_data : data_q;
  assign idx      = 17'((addr_src - BASE_ADDR) >> 2);
  assign in_beat  = (state_nxt == LO) || (state_nxt == HI);
  assign hi_nxt   = (state_nxt == HI);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and stall decode.
  always_comb begin
    state_nxt = state;
    bus.ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = !req;
        if (req) state_nxt = LO;
      end
      LO:   if (last) state_nxt = HI;
      HI:   if (last) state_nxt = DONE;
      DONE: begin
        bus.ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request; a write wins over a simultaneous read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
    end else if (state == IDLE && req) begin
      wr_q <= bus.wr_en;
    end
    if (state == IDLE && req) begin
      addr_q <= bus.address;
      data_q <= bus.wr_data;
    end
  end

  // Registered SRAM pins, computed for the cycle being entered.
  always_ff @(posedge clk) begin
    if (rst || !in_beat) begin
      bus.sram_addr   <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe  <= 1'b0;
      bus.sram_we_n   <= 1'b1;
      bus.sram_oe_n   <= 1'b1;
    end else begin
      bus.sram_addr   <= {idx, hi_nxt};
      bus.sram_dq_out <= op_wr ? (hi_nxt ? data_src[31:16] : data_src[15:0]) : '0;
      bus.sram_dq_oe  <= op_wr;
      bus.sram_we_n   <= !(op_wr && (cnt_nxt < WS));
      bus.sram_oe_n   <= op_wr;
    end
  end

  // Capture read halves in the final cycle of each beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data <= '0;
    end else if (last && !wr_q) begin
      if (state == LO) bus.rd_data[15:0]  <= bus.sram_dq_in;
      if (state == HI) bus.rd_data[31:16] <= bus.sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (1 and 3 wait states) against SRAM
// models and a word-level reference memory.
module tb_sram_ctrl;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, wr_data = '0;

  logic [15:0] sram [2][1024];
  logic [31:0] ref_mem [2][256];
  logic [31:0] exp_rd [2];

  int checks = 0;
  int errors = 0;

  sram_ctrl_if bus0 ();
  sram_ctrl_if bus1 ();

  sram_ctrl #(.BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  sram_ctrl #(.BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  assign bus0.wr_en   = wr_en & ~sel;
  assign bus0.rd_en   = rd_en & ~sel;
  assign bus0.address = address;
  assign bus0.wr_data = wr_data;
  assign bus1.wr_en   = wr_en & sel;
  assign bus1.rd_en   = rd_en & sel;
  assign bus1.address = address;
  assign bus1.wr_data = wr_data;

  assign bus0.sram_dq_in = sram[0][bus0.sram_addr[9:0]];
  assign bus1.sram_dq_in = sram[1][bus1.sram_addr[9:0]];

  // Asynchronous SRAM models: data is taken while the strobe is low.
  always @(posedge clk) begin
    if (!bus0.sram_we_n) sram[0][bus0.sram_addr[9:0]] <= bus0.sram_dq_out;
    if (!bus1.sram_we_n) sram[1][bus1.sram_addr[9:0]] <= bus1.sram_dq_out;
  end

  wire        ready_s = sel ? bus1.ready      : bus0.ready;
  wire [31:0] rd_s    = sel ? bus1.rd_data    : bus0.rd_data;
  wire [17:0] addr_s  = sel ? bus1.sram_addr  : bus0.sram_addr;
  wire        we_n_s  = sel ? bus1.sram_we_n  : bus0.sram_we_n;
  wire        oe_n_s  = sel ? bus1.sram_oe_n  : bus0.sram_oe_n;
  wire        dqoe_s  = sel ? bus1.sram_dq_oe : bus0.sram_dq_oe;
  wire [15:0] dqo_s   = sel ? bus1.sram_dq_out: bus0.sram_dq_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access; called #1 after a rising edge, returns #1 after the edge leaving DONE.
  task automatic do_access(input bit s, input bit w, input bit r, input int idx, input logic [31:0] d);
    int ws, low, welow, cyc;
    bit done, seen;
    logic [17:0] a_first, a_last;
    ws = s ? 3 : 1;
    low = 0; welow = 0; cyc = 0; done = 0; seen = 0;
    a_first = '0; a_last = '0;
    sel = s; wr_en = w; rd_en = r;
    address = BASE + 32'(idx) * 4; wr_data = d;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("idle_stall", 32'(ready_s), 32'd0);
      if (!we_n_s) welow++;
      if (!oe_n_s || dqoe_s) begin
        if (!seen) a_first = addr_s;
        seen = 1;
        a_last = addr_s;
      end
      if (ready_s) done = 1;
      else         low++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("stall_len", 32'(low), 32'(2 * (ws + 1) + 1));
    chk("we_low", 32'(welow), w ? 32'(2 * ws) : 32'd0);
    chk("addr_lo", 32'(a_first), 32'(2 * idx));
    chk("addr_hi", 32'(a_last), 32'(2 * idx + 1));
    if (w)      ref_mem[s][idx] = d;
    else if (r) exp_rd[s] = ref_mem[s][idx];
    chk("rd_data", rd_s, exp_rd[s]);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (w) begin
      chk("mem_lo", 32'(sram[s][2 * idx]), 32'(d[15:0]));
      chk("mem_hi", 32'(sram[s][2 * idx + 1]), 32'(d[31:16]));
    end
  endtask

  initial begin
    int s, k, idx;
    for (int m = 0; m < 2; m++) begin
      exp_rd[m] = '0;
      for (int i = 0; i < 256; i++) begin
        ref_mem[m][i] = $urandom;
        sram[m][2 * i]     = ref_mem[m][i][15:0];
        sram[m][2 * i + 1] = ref_mem[m][i][31:16];
      end
      for (int i = 512; i < 1024; i++) sram[m][i] = '0;
    end
    ref_mem[0][2] = 32'h1234_5678;
    sram[0][4] = 16'h5678;
    sram[0][5] = 16'h1234;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus0.ready), 32'd1);
    chk("rst_we_n", 32'(bus0.sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(bus0.sram_oe_n), 32'd1);
    chk("rst_dq_oe", 32'(bus0.sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(bus0.sram_addr), 32'd0);
    chk("rst_dq_out", 32'(bus0.sram_dq_out), 32'd0);
    chk("rst_rd_data", bus0.rd_data, 32'd0);
    chk("rst_rd_data1", bus1.rd_data, 32'd0);
    @(posedge clk);
    #1;

    // Store then load back-to-back, then the mapping example.
    do_access(0, 1, 0, 0, 32'hDEAD_BEEF);
    do_access(0, 0, 1, 0, 32'h0);
    do_access(0, 0, 1, 2, 32'h0);

    // Conflicting request on the 3-wait-state instance.
    do_access(1, 1, 1, 5, 32'hCAFE_F00D);

    // Idle window.
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready_s), 32'd1);
      chk("idle_pins", {30'd0, oe_n_s, we_n_s}, 32'd3);
      chk("idle_rd", rd_s, exp_rd[0]);
    end
    @(posedge clk);
    #1;

    // Randomized traffic on both instances.
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 1);
      k = $urandom_range(0, 2);
      idx = $urandom_range(0, 255);
      do_access(s[0], k != 1, k != 0, idx, $urandom);
    end

    // Reset during the HI beat of a store.
    sel = 0; wr_en = 1'b1; rd_en = 1'b0;
    address = BASE + 32'd300 * 4; wr_data = 32'hA5A5_5A5A;
    repeat (3) @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("hi_before_rst", 32'(addr_s), 32'd601);
    chk("hi_we_n", 32'(dqo_s), 32'h0000_A5A5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_rd[0] = '0;
    chk("mid_rst_we_n", 32'(we_n_s), 32'd1);
    chk("mid_rst_dq_oe", 32'(dqoe_s), 32'd0);
    chk("mid_rst_rd", rd_s, exp_rd[0]);
    chk("mid_rst_ready", 32'(ready_s), 32'd1);
    @(posedge clk);
    #1;
    do_access(0, 0, 1, 2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
